// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM states, beat counter and id helpers.
package fifo_arb_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int AWIDTH_DEF = 4;
    localparam int IDW        = $clog2(NREQ_DEF);
    localparam int DEPTH      = 2 ** AWIDTH_DEF;

    typedef enum logic {IDLE, BURST} arb_state_t;
    typedef logic [IDW-1:0] req_id_t;
    typedef logic [7:0]     beat_t;

    // Round-robin successor of a requester id among n requesters.
    function automatic int wrap_inc(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  winner,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW:0]      off;
    logic [IDW:0]      sum;

    // rot[i] is the request sitting i places after rr_ptr.
    assign dbl = {req, req};
    assign rot = NREQ'(dbl >> rr_ptr);
    assign any = |req;

    always_comb begin
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = (IDW+1)'(i);
        end
    end

    always_comb begin
        sum = {1'b0, rr_ptr} + off;
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        winner = sum[IDW-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one sync FIFO write port among NREQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 16,
    parameter int AWIDTH    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic [AWIDTH:0]          fifo_dcount,
    input  logic                     fifo_full,
    output logic [DWIDTH-1:0]        fifo_din,
    output logic                     fifo_we,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int              GW        = $clog2(NREQ);
    localparam int              OCCW      = AWIDTH + 2;
    localparam logic [OCCW-1:0] FDEPTH    = OCCW'(2 ** AWIDTH);
    localparam beat_t           LAST_BEAT = beat_t'(MAX_BURST - 1);

    arb_state_t                   state;
    logic [GW-1:0]                rr_ptr;
    logic [GW-1:0]                winner;
    logic [GW-1:0]                next_id;
    logic                         any;
    beat_t                        beat_cnt;
    logic [NREQ-1:0][DWIDTH-1:0]  req_words;
    logic [OCCW-1:0]              occ;
    logic                         space_ok;
    logic                         gnt_valid;
    logic                         accept;

    assign req_words = req_data;

    // The word registered last cycle is not yet reflected in fifo_dcount.
    assign occ      = OCCW'(fifo_dcount) + OCCW'(fifo_we);
    assign space_ok = ~fifo_full & (occ < FDEPTH);

    assign gnt_valid = req_valid[grant_id];
    assign accept    = gnt_valid & req_ready[grant_id];
    assign next_id   = GW'(wrap_inc(int'(grant_id), NREQ));
    assign busy      = (state == BURST);

    always_comb begin
        req_ready = '0;
        if (!rst && state == BURST) req_ready[grant_id] = space_ok;
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (GW)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
            fifo_we  <= 1'b0;
            fifo_din <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fifo_we <= 1'b0;
                    if (any) begin
                        grant_id <= winner;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    fifo_we <= accept;
                    if (accept) begin
                        fifo_din <= req_words[grant_id];
                        beat_cnt <= beat_cnt + beat_t'(1);
                    end
                    // Space stalls keep the grant; only a full burst or a drop-out rotates.
                    if ((accept && beat_cnt == LAST_BEAT) || !gnt_valid) begin
                        state  <= IDLE;
                        rr_ptr <= next_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-based FIFO and producers, spec-level model checked every cycle.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [4:0]  fifo_dcount = '0;
    logic        fifo_full = 1'b0;
    logic [15:0] fifo_din;
    logic        fifo_we;
    logic [1:0]  grant_id;
    logic        busy;
    logic        rd_en;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(4), .DWIDTH(16), .AWIDTH(4), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_dcount(fifo_dcount), .fifo_full(fifo_full), .fifo_din(fifo_din), .fifo_we(fifo_we),
        .grant_id(grant_id), .busy(busy)
    );

    // Producers: per-requester word lists; valid while words remain.
    logic [15:0] pmem [NREQ][64];
    int          phead [NREQ];
    int          ptail [NREQ];
    int          acc_cnt [NREQ];

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = (phead[i] != ptail[i]);
            req_data[i*16 +: 16] = pmem[i][6'(phead[i])];
        end
    end

    // FIFO: 16 deep, dcount/full updated at the clock edge.
    logic [15:0] fq[$];
    logic [15:0] rd_log[$];
    always @(posedge clk) begin
        if (rst) fq.delete();
        else begin
            if (rd_en && fq.size() > 0) rd_log.push_back(fq.pop_front());
            if (fifo_we && fq.size() < 16) fq.push_back(fifo_din);
        end
        fifo_dcount <= 5'(fq.size());
        fifo_full   <= (fq.size() == 16);
    end

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          m_known = 0;
    logic        m_busy, m_we;
    logic [15:0] m_din;
    int          m_grant, m_ptr, m_beats;
    logic [3:0]  fire;
    logic [15:0] wr_d[$];
    int          wr_c[$];
    int          g_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int r, input logic [15:0] w);
        pmem[r][6'(ptail[r])] = w;
        ptail[r]++;
    endtask

    // One clock: compare at negedge, advance model, then retire handshakes after the edge.
    task automatic cycle();
        logic [3:0] exp_rdy;
        int occ;
        logic acc;
        @(negedge clk);
        exp_rdy = '0;
        if (!rst && m_known && m_busy) begin
            occ = int'(fifo_dcount) + int'(m_we);
            if (!fifo_full && occ < 16) exp_rdy[m_grant] = 1'b1;
        end
        if (rst || m_known) chk("req_ready", req_ready, exp_rdy);
        if (m_known) begin
            chk("fifo_we", fifo_we, m_we);
            chk("fifo_din", fifo_din, m_din);
            chk("busy", busy, m_busy);
            chk("grant_id", grant_id, m_grant);
        end
        if (fifo_we) begin
            chk("we_while_full", fifo_full, 0);
            wr_d.push_back(fifo_din);
            wr_c.push_back(cyc);
        end
        fire = req_valid & req_ready;
        if (rst) begin
            m_known = 1; m_busy = 0; m_we = 0; m_din = '0;
            m_grant = 0; m_ptr = 0; m_beats = 0;
        end else if (m_known) begin
            if (!m_busy) begin
                m_we = 0;
                if (req_valid != 0) begin
                    for (int k = NREQ - 1; k >= 0; k--)
                        if (req_valid[(m_ptr + k) % NREQ]) m_grant = (m_ptr + k) % NREQ;
                    m_busy = 1; m_beats = 0;
                    g_log.push_back(m_grant);
                end
            end else begin
                acc  = req_valid[m_grant] && exp_rdy[m_grant];
                m_we = acc;
                if (acc) begin
                    m_din = req_data[m_grant*16 +: 16];
                    m_beats++;
                end
                if ((acc && m_beats == MAXB) || !req_valid[m_grant]) begin
                    m_busy = 0;
                    m_ptr  = (m_grant + 1) % NREQ;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (fire[i]) begin phead[i]++; acc_cnt[i]++; end
        cyc++;
    endtask

    function automatic bit quiet();
        for (int i = 0; i < NREQ; i++) if (phead[i] != ptail[i]) return 0;
        return !busy && !fifo_we;
    endfunction

    task automatic run_until_done(input string nm, input int budget);
        bit done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            cycle();
            done = quiet();
        end
        chk(nm, done, 1);
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) phead[i] = ptail[i];
        repeat (2) cycle();
        rst = 1'b0;
        wr_d.delete(); wr_c.delete(); g_log.delete();
    endtask

    task automatic drain(input string nm, input int n, input int base, input logic [15:0] first, input int step);
        rd_en = 1'b1;
        repeat (n) cycle();
        rd_en = 1'b0;
        cycle();
        chk({nm, "_rd_cnt"}, rd_log.size() - base, n);
        for (int k = 0; k < n; k++)
            if (base + k < rd_log.size())
                chk({nm, "_rd_order"}, rd_log[base + k], 16'(int'(first) + (k / 4) * step + (k % 4)));
    endtask

    initial begin
        int rb, a0;
        bit reached;
        rst = 1'b1; rd_en = 1'b0;
        for (int i = 0; i < NREQ; i++) begin phead[i] = 0; ptail[i] = 0; acc_cnt[i] = 0; end

        // Reset held 3 cycles with every requester valid.
        for (int i = 0; i < NREQ; i++) push(i, 16'h0F00 + 16'(i));
        repeat (3) begin
            cycle();
            chk("rst_ready", req_ready, 4'b0000);
            chk("rst_we", fifo_we, 0);
            chk("rst_busy", busy, 0);
            chk("rst_grant", grant_id, 0);
        end
        chk("rst_valid_held", req_valid, 4'b1111);
        do_reset();

        // Single requester 2, six words: 4-beat burst, one bubble, 2-beat burst.
        for (int k = 0; k < 6; k++) push(2, 16'h00A0 + 16'(k));
        run_until_done("t1_timeout", 40);
        chk("t1_wr_cnt", wr_d.size(), 6);
        for (int k = 0; k < 6 && k < wr_d.size(); k++) chk("t1_data", wr_d[k], 16'h00A0 + 16'(k));
        if (wr_c.size() == 6) begin
            chk("t1_gap01", wr_c[1] - wr_c[0], 1);
            chk("t1_gap23", wr_c[3] - wr_c[2], 1);
            chk("t1_bubble", wr_c[4] - wr_c[3], 2);
            chk("t1_gap45", wr_c[5] - wr_c[4], 1);
        end
        chk("t1_bursts", g_log.size(), 2);
        if (g_log.size() == 2) begin
            chk("t1_grant0", g_log[0], 2);
            chk("t1_grant1", g_log[1], 2);
        end
        chk("t1_dcount", fifo_dcount, 6);
        rb = rd_log.size();
        drain("t1", 6, rb, 16'h00A0, 4);
        do_reset();

        // All four valid, four words each: grants 0,1,2,3 with one bubble between bursts.
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 4; k++) push(i, 16'(i * 16'h0100 + k));
        run_until_done("t2_timeout", 60);
        chk("t2_bursts", g_log.size(), 4);
        for (int b = 0; b < 4 && b < g_log.size(); b++) chk("t2_grant_order", g_log[b], b);
        begin
            int bubbles = 0;
            for (int k = 1; k < wr_c.size(); k++) if (wr_c[k] - wr_c[k-1] == 2) bubbles++;
            chk("t2_bubbles", bubbles, 3);
        end
        chk("t2_dcount", fifo_dcount, 16);
        chk("t2_full", fifo_full, 1);
        rb = rd_log.size();
        drain("t2", 16, rb, 16'h0000, 16'h0100);
        do_reset();

        // Backpressure: no reads, 20 words offered, FIFO fills at 16.
        a0 = acc_cnt[0];
        for (int k = 0; k < 20; k++) push(0, 16'h0B00 + 16'(k));
        repeat (40) cycle();
        chk("t3_accepted", acc_cnt[0] - a0, 16);
        chk("t3_dcount", fifo_dcount, 16);
        chk("t3_full", fifo_full, 1);
        chk("t3_ready_low", req_ready, 4'b0000);
        chk("t3_stall_busy", busy, 1);
        chk("t3_stall_grant", grant_id, 0);
        rb = rd_log.size();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        repeat (10) cycle();
        chk("t3_one_more", acc_cnt[0] - a0, 17);
        chk("t3_dcount2", fifo_dcount, 16);
        chk("t3_rd_cnt", rd_log.size() - rb, 1);
        if (rd_log.size() > rb) chk("t3_rd_word", rd_log[rb], 16'h0B00);
        do_reset();

        // Drop-out: requester 1 gives 2 words, requester 3 is next (scan from 2 skips 2).
        push(1, 16'h00C0); push(1, 16'h00C1);
        for (int k = 0; k < 3; k++) push(3, 16'h00D0 + 16'(k));
        run_until_done("t4_timeout", 40);
        chk("t4_bursts", g_log.size(), 2);
        if (g_log.size() == 2) begin
            chk("t4_grant0", g_log[0], 1);
            chk("t4_grant1", g_log[1], 3);
        end
        chk("t4_wr_cnt", wr_d.size(), 5);
        if (wr_d.size() == 5) begin
            chk("t4_w0", wr_d[0], 16'h00C0);
            chk("t4_w1", wr_d[1], 16'h00C1);
            chk("t4_w2", wr_d[2], 16'h00D0);
            chk("t4_w4", wr_d[4], 16'h00D2);
            chk("t4_handover", wr_c[2] - wr_c[1], 3);
        end
        do_reset();

        // Reset mid-burst: rr_ptr must return to 0 afterwards.
        push(0, 16'h00E0);
        run_until_done("t5_pre_timeout", 20);
        for (int k = 0; k < 4; k++) push(1, 16'h00F0 + 16'(k));
        a0 = acc_cnt[1];
        reached = 0;
        for (int n = 0; n < 20 && !reached; n++) begin
            cycle();
            reached = (acc_cnt[1] - a0 == 2);
        end
        chk("t5_two_beats", reached, 1);
        rst = 1'b1;
        cycle();
        chk("t5_we_after_rst", fifo_we, 0);
        chk("t5_busy_after_rst", busy, 0);
        rst = 1'b0;
        wr_d.delete(); wr_c.delete(); g_log.delete();
        push(0, 16'h00E1);
        run_until_done("t5_timeout", 40);
        chk("t5_bursts", g_log.size(), 2);
        if (g_log.size() == 2) begin
            chk("t5_grant0", g_log[0], 0);
            chk("t5_grant1", g_log[1], 1);
        end
        chk("t5_wr_cnt", wr_d.size(), 3);
        if (wr_d.size() == 3) begin
            chk("t5_w0", wr_d[0], 16'h00E1);
            chk("t5_w1", wr_d[1], 16'h00F2);
            chk("t5_w2", wr_d[2], 16'h00F3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
